carrier_generator: RTL and testbench

CARRIER_GENERATOR -- requirements
Module: carrier_generator

---
 rtl/carrier_generator_pkg.sv | 16 +
 rtl/carrier_generator_recip_divider.sv | 84 ++++++++
 rtl/carrier_generator.sv | 147 ++++++++++++++
 tb/tb_carrier_generator.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/carrier_generator_pkg.sv
// Shared constants and types for the level-shifted triangle carrier generator.
package carrier_generator_pkg;

   localparam int CARR_MAX = 32767;
   localparam int K_SHIFT  = 16;
   localparam int MIN_DIV  = 2;

   // Reciprocal numerator: CARR_MAX << K_SHIFT
   localparam logic [31:0] K_NUM = 32'h7FFF_0000;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/carrier_generator_recip_divider.sv
// Sequential restoring divider, one quotient bit per cycle; done pulses with the result.
module recip_divider #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [31:0]      dividend_i,
   input  logic [DIV_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [31:0]      quotient_o
);

   logic [DIV_W-1:0] rem_q, rem_d;
   logic [31:0]      quo_q, quo_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       bit_q, bit_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [DIV_W:0]   trial_s;
   logic [DIV_W:0]   diff_s;

   assign trial_s = {rem_q, quo_q[31]};
   assign diff_s  = trial_s - {1'b0, div_q};

   // Next-state logic: load operands on start, then shift/subtract for 32 cycles
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      div_d  = div_q;
      bit_d  = bit_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (busy_q) begin
         if (trial_s >= {1'b0, div_q}) begin
            rem_d = DIV_W'(diff_s);
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = DIV_W'(trial_s);
            quo_d = {quo_q[30:0], 1'b0};
         end
         bit_d = bit_q - 6'd1;
         if (bit_q == 6'd1) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end else if (start_i) begin
         rem_d  = {DIV_W{1'b0}};
         quo_d  = dividend_i;
         div_d  = divisor_i;
         bit_d  = 6'd32;
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Divider state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= {DIV_W{1'b0}};
         quo_q  <= 32'd0;
         div_q  <= {DIV_W{1'b0}};
         bit_q  <= 6'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
         bit_q  <= bit_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/carrier_generator.sv
// Two level-shifted triangle carriers with a trough sync strobe; divisor changes
// take effect only at a trough so a period never mixes divisors.
module carrier_generator
   import carrier_generator_pkg::*;
#(
   parameter int CARRIER_WIDTH = 16,
   parameter int COUNTER_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            enable,
   input  logic [COUNTER_WIDTH-1:0]        freq_div,
   output logic signed [CARRIER_WIDTH-1:0] carrier1,
   output logic signed [CARRIER_WIDTH-1:0] carrier2,
   output logic                            sync_pulse
);

   localparam logic signed [CARRIER_WIDTH-1:0] CMAX_S = CARRIER_WIDTH'(CARR_MAX);
   localparam logic [COUNTER_WIDTH-1:0]        DMIN_S = COUNTER_WIDTH'(MIN_DIV);

   logic [COUNTER_WIDTH-1:0]        cnt_q, cnt_d;
   dir_e                            dir_q, dir_d;
   logic [COUNTER_WIDTH-1:0]        d_q, d_d;
   logic [31:0]                     k_q, k_d;
   logic [COUNTER_WIDTH-1:0]        tgt_q, tgt_d;
   logic [COUNTER_WIDTH-1:0]        pend_div_q, pend_div_d;
   logic [31:0]                     pend_k_q, pend_k_d;
   logic                            pend_q, pend_d;
   logic signed [CARRIER_WIDTH-1:0] c1_q, c1_d;
   logic signed [CARRIER_WIDTH-1:0] c2_q, c2_d;
   logic                            sync_q, sync_d;

   logic [COUNTER_WIDTH-1:0]        clamp_s;
   logic                            trough_s, sample_s, start_s;
   logic                            div_busy_s, div_done_s;
   logic [31:0]                     quo_s;
   logic [COUNTER_WIDTH+31:0]       prod_s;
   logic signed [CARRIER_WIDTH-1:0] t_s;

   assign clamp_s  = (freq_div < DMIN_S) ? DMIN_S : freq_div;
   assign trough_s = (cnt_q == {COUNTER_WIDTH{1'b0}});
   assign sample_s = trough_s || !enable;
   // tgt_q resets to 0 so the first sample after reset always launches a division
   assign start_s  = sample_s && !div_busy_s && (clamp_s != tgt_q);
   assign prod_s   = {{COUNTER_WIDTH{1'b0}}, k_q} * {32'd0, cnt_q};
   assign t_s      = $signed(CARRIER_WIDTH'(prod_s >> K_SHIFT));

   recip_divider #(.DIV_W(COUNTER_WIDTH)) u_recip (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_s),
      .dividend_i (K_NUM),
      .divisor_i  (clamp_s),
      .busy_o     (div_busy_s),
      .done_o     (div_done_s),
      .quotient_o (quo_s)
   );

   // Counter, divisor bookkeeping and output next-state
   always_comb begin
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      d_d        = d_q;
      k_d        = k_q;
      tgt_d      = tgt_q;
      pend_div_d = pend_div_q;
      pend_k_d   = pend_k_q;
      pend_d     = pend_q;

      if (start_s) begin
         tgt_d = clamp_s;
      end else begin
         tgt_d = tgt_q;
      end

      if (pend_q && sample_s) begin
         d_d    = pend_div_q;
         k_d    = pend_k_q;
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end

      if (div_done_s) begin
         pend_div_d = tgt_q;
         pend_k_d   = quo_s;
         pend_d     = 1'b1;
      end else begin
         pend_div_d = pend_div_q;
      end

      if (!enable) begin
         cnt_d = {COUNTER_WIDTH{1'b0}};
         dir_d = DIR_UP;
      end else if (dir_q == DIR_UP) begin
         cnt_d = cnt_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
         dir_d = (cnt_d == d_q) ? DIR_DOWN : DIR_UP;
      end else begin
         cnt_d = cnt_q - {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
         dir_d = (cnt_d == {COUNTER_WIDTH{1'b0}}) ? DIR_UP : DIR_DOWN;
      end

      if (!enable) begin
         c2_d   = {CARRIER_WIDTH{1'b0}};
         c1_d   = -CMAX_S;
         sync_d = 1'b0;
      end else begin
         c2_d   = t_s;
         c1_d   = t_s - CMAX_S;
         sync_d = trough_s;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= {COUNTER_WIDTH{1'b0}};
         dir_q      <= DIR_UP;
         d_q        <= DMIN_S;
         k_q        <= 32'd0;
         tgt_q      <= {COUNTER_WIDTH{1'b0}};
         pend_div_q <= DMIN_S;
         pend_k_q   <= 32'd0;
         pend_q     <= 1'b0;
         c1_q       <= -CMAX_S;
         c2_q       <= {CARRIER_WIDTH{1'b0}};
         sync_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         d_q        <= d_d;
         k_q        <= k_d;
         tgt_q      <= tgt_d;
         pend_div_q <= pend_div_d;
         pend_k_q   <= pend_k_d;
         pend_q     <= pend_d;
         c1_q       <= c1_d;
         c2_q       <= c2_d;
         sync_q     <= sync_d;
      end
   end

   assign carrier1   = c1_q;
   assign carrier2   = c2_q;
   assign sync_pulse = sync_q;

endmodule

// File: tb/tb_carrier_generator.sv
// Directed bench for carrier_generator: per-divisor vector table plus enable,
// divisor-change and asynchronous-reset sequences.
module tb_carrier_generator;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic [15:0]        freq_div = 16'd100;
   logic signed [15:0] carrier1;
   logic signed [15:0] carrier2;
   logic               sync_pulse;

   int checks = 0;
   int failures = 0;
   bit mon_on = 1'b0;

   typedef struct {
      logic [15:0] fdiv;
      int          period;
      int          peak;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   carrier_generator #(.CARRIER_WIDTH(16), .COUNTER_WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .freq_div   (freq_div),
      .carrier1   (carrier1),
      .carrier2   (carrier2),
      .sync_pulse (sync_pulse)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Cycles until the next sync strobe, plus the largest carrier2 seen on the way
   task automatic wait_sync(input int limit, output int n, output int pk);
      n  = 0;
      pk = 0;
      do begin
         @(negedge clk);
         n++;
         if (int'(carrier2) > pk) pk = int'(carrier2);
      end while (!sync_pulse && n < limit);
      if (!sync_pulse) begin
         chk("sync_timeout", int'(sync_pulse), 1);
         n = -1;
      end
   endtask

   // Range and level-shift relation on every sampled cycle
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (carrier2 < 0 || carrier2 > 32767 || carrier1 > 0 || carrier1 < -32768 ||
             int'(carrier1) != int'(carrier2) - 32767) begin
            failures++;
            $display("FAIL range: carrier1=%0d carrier2=%0d", carrier1, carrier2);
         end
      end
   end

   initial begin
      int n;
      int pk;

      vecs[0] = '{16'd100, 200, 32766};
      vecs[1] = '{16'd0,   4,   32767};
      vecs[2] = '{16'd1,   4,   32767};
      vecs[3] = '{16'd2,   4,   32767};
      vecs[4] = '{16'd3,   6,   32766};
      vecs[5] = '{16'd50,  100, 32766};
      vecs[6] = '{16'd200, 400, 32766};

      #12;
      chk("reset_c1", int'(carrier1), -32767);
      chk("reset_c2", int'(carrier2), 0);
      chk("reset_sync", int'(sync_pulse), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_on = 1'b1;

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         enable   = 1'b0;
         freq_div = vecs[i].fdiv;
         repeat (40) @(negedge clk);
         chk("idle_c2", int'(carrier2), 0);
         enable = 1'b1;
         @(negedge clk);
         chk("first_sync", int'(sync_pulse), 1);
         wait_sync(1000, n, pk);
         chk("period", n, vecs[i].period);
         chk("peak", pk, vecs[i].peak);
      end

      // Steady run at freq_div=100
      @(negedge clk);
      enable   = 1'b0;
      freq_div = 16'd100;
      repeat (40) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      chk("run_first_sync", int'(sync_pulse), 1);
      for (int p = 0; p < 3; p++) begin
         wait_sync(1000, n, pk);
         chk("run_period", n, 200);
         chk("run_peak", pk, 32766);
      end

      // Enable dropped mid-period for 20 cycles
      repeat (50) @(negedge clk);
      enable = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("off_c2", int'(carrier2), 0);
         chk("off_c1", int'(carrier1), -32767);
         chk("off_sync", int'(sync_pulse), 0);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("reen_sync", int'(sync_pulse), 1);
      wait_sync(1000, n, pk);
      chk("reen_period", n, 200);

      // Divisor change mid-period: current period is undisturbed, later ones use 400
      repeat (50) @(negedge clk);
      freq_div = 16'd200;
      wait_sync(1000, n, pk);
      chk("chg_cur_period", 50 + n, 200);
      wait_sync(1000, n, pk);
      wait_sync(1000, n, pk);
      chk("chg_new_period", n, 400);
      chk("chg_new_peak", pk, 32766);
      wait_sync(1000, n, pk);
      chk("chg_new_period2", n, 400);

      // Asynchronous reset mid-period
      repeat (100) @(negedge clk);
      chk("pre_reset_c2", int'(carrier2), 16383);
      #2 rst_n = 1'b0;
      #1;
      chk("async_c2", int'(carrier2), 0);
      chk("async_c1", int'(carrier1), -32767);
      chk("async_sync", int'(sync_pulse), 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("inreset_sync", int'(sync_pulse), 0);
         chk("inreset_c2", int'(carrier2), 0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("preload_c2", int'(carrier2), 0);
      end
      repeat (40) @(negedge clk);
      wait_sync(1000, n, pk);
      wait_sync(1000, n, pk);
      chk("post_reset_period", n, 400);
      chk("post_reset_peak", pk, 32766);

      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
